// File: rtl/qspi_video_line_fetcher_pkg.sv
// Shared definitions for the QSPI video line fetcher: 23LC1024 instruction
// codes, FSM state encoding, phase lengths and the registered SRAM pin bundle.
package qspi_video_line_fetcher_pkg;

  // 23LC1024 instruction codes
  localparam logic [7:0] SRAM_CMD_READ  = 8'h03;
  localparam logic [7:0] SRAM_CMD_EQIO  = 8'h38;
  localparam logic [7:0] SRAM_CMD_RSTIO = 8'hFF;

  // Phase lengths in SCK cycles (nibbles in SQI mode)
  localparam int unsigned CMD_NIBBLES     = 2;
  localparam int unsigned ADDR_NIBBLES    = 6;
  localparam int unsigned DUMMY_CYCLES    = 2;
  localparam int unsigned INIT_SCK_CYCLES = 8;
  localparam int unsigned GAP_CLKS        = 2;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    ST_RST_IO,
    ST_GAP1,
    ST_EQIO,
    ST_GAP2,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_END
  } fsm_state_e;

  // SRAM-facing pins, registered as one bundle
  typedef struct packed {
    logic       cs_n;
    logic       sck;
    logic       oe;
    logic [3:0] sio;
  } sram_pins_t;

  // Length of each state in clk cycles. RST_IO carries one extra leading
  // cycle with CS_n still high, so its SCK cycles start at count 1.
  function automatic logic [CNT_W-1:0] phase_clks(input fsm_state_e s,
                                                  input logic [CNT_W-1:0] data_clks);
    logic [CNT_W-1:0] n;
    case (s)
      ST_RST_IO:        n = CNT_W'(2 * INIT_SCK_CYCLES + 1);
      ST_GAP1, ST_GAP2: n = CNT_W'(GAP_CLKS);
      ST_EQIO:          n = CNT_W'(2 * INIT_SCK_CYCLES);
      ST_CMD:           n = CNT_W'(2 * CMD_NIBBLES);
      ST_ADDR:          n = CNT_W'(2 * ADDR_NIBBLES);
      ST_DUMMY:         n = CNT_W'(2 * DUMMY_CYCLES);
      ST_DATA:          n = data_clks;
      default:          n = CNT_W'(1);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qspi_video_line_fetcher_bank.sv
// video_line_bank: ping-pong 1-bpp line store, 2 x WIDTH bits.
// Ports: clk/reset; nibble write port (wr_en, wr_bank, wr_idx, wr_data with
// wr_data[3] = lowest pixel of the nibble); registered 1-bit read port
// (rd_bank, rd_addr -> rd_data, 0 when rd_addr >= WIDTH).
module video_line_bank #(
  parameter int unsigned WIDTH = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       wr_bank,
  input  logic [$clog2(WIDTH)-3:0]   wr_idx,
  input  logic [3:0]                 wr_data,
  input  logic                       rd_bank,
  input  logic [9:0]                 rd_addr,
  output logic                       rd_data
);

  localparam int unsigned AW = $clog2(WIDTH);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  rd_q, rd_d;

  // Nibble write: first pixel of the group comes from sio[3]
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        mem_d[wr_bank][{wr_idx, 2'(i)}] = wr_data[2'(3 - i)];
      end
    end
  end

  // Out-of-range read positions show black
  always_comb begin
    rd_d = 1'b0;
    if (32'(rd_addr) < WIDTH) begin
      rd_d = mem_q[rd_bank][AW'(rd_addr)];
    end
  end

  // Storage is not reset; contents are meaningless until a line is fetched
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_q <= 1'b0;
    else       rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/qspi_video_line_fetcher.sv
// qspi_video_line_fetcher: initialises a 23LC1024 into SQI mode, then on
// request reads one line of 1-bpp pixels into the back bank of a ping-pong
// line store while the front bank is displayed.
// Ports: clk/reset (sync, active-high); fetch_req/fetch_line request;
// swap toggles the display bank; rd_hpos -> pixel_out (one clk latency);
// initialized/fetch_busy/fetch_done status; sram_* QSPI pins.
module qspi_video_line_fetcher
  import qspi_video_line_fetcher_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 512,
  parameter int unsigned SCREEN_HEIGHT = 256,
  parameter logic [23:0] BASE_ADDR     = 24'h000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic [9:0] fetch_line,
  input  logic       swap,
  input  logic [9:0] rd_hpos,
  output logic       pixel_out,
  output logic       initialized,
  output logic       fetch_busy,
  output logic       fetch_done,
  output logic       sram_cs_n,
  output logic       sram_sck,
  output logic       sram_sio_oe,
  output logic [3:0] sram_sio_o,
  input  logic [3:0] sram_sio_i
);

  localparam int unsigned PIX_AW     = $clog2(SCREEN_WIDTH);
  localparam int unsigned NIB_AW     = PIX_AW - 2;
  localparam int unsigned LINE_BYTES = SCREEN_WIDTH / 8;
  localparam logic [CNT_W-1:0] DATA_CLKS = CNT_W'(SCREEN_WIDTH / 2);

  localparam sram_pins_t PINS_IDLE = '{cs_n: 1'b1, sck: 1'b0, oe: 1'b1, sio: 4'hF};

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      addr_q, addr_d;
  logic             wbank_q, wbank_d;
  logic             disp_q, disp_d;
  logic             init_q, init_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  sram_pins_t       pins_q, pins_d;
  logic [3:0]       sck_k;

  // Next state, counter and transaction latches
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    addr_d  = addr_q;
    wbank_d = wbank_q;
    disp_d  = disp_q ^ swap;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (fetch_req && init_q && (32'(fetch_line) < SCREEN_HEIGHT)) begin
        state_d = ST_CMD;
        addr_d  = 24'(32'(BASE_ADDR) + 32'(fetch_line) * LINE_BYTES);
        wbank_d = ~disp_q;
      end
    end else if (cnt_q == phase_clks(state_q, DATA_CLKS) - CNT_W'(1)) begin
      cnt_d = '0;
      case (state_q)
        ST_RST_IO: state_d = ST_GAP1;
        ST_GAP1:   state_d = ST_EQIO;
        ST_EQIO:   state_d = ST_GAP2;
        ST_GAP2:   state_d = ST_IDLE;
        ST_CMD:    state_d = ST_ADDR;
        ST_ADDR:   state_d = ST_DUMMY;
        ST_DUMMY:  state_d = ST_DATA;
        ST_DATA:   state_d = ST_END;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Pin values for the upcoming cycle, derived from the next state/count
  always_comb begin
    init_d = init_q | (state_d == ST_IDLE);
    busy_d = state_d inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END};
    done_d = (state_d == ST_END);
    sck_k  = 4'((state_d == ST_RST_IO) ? cnt_d - CNT_W'(1) : cnt_d);
    pins_d = PINS_IDLE;
    case (state_d)
      ST_RST_IO: begin
        if (cnt_d != '0) begin
          pins_d.cs_n = 1'b0;
          pins_d.sck  = sck_k[0];
          pins_d.sio  = SRAM_CMD_RSTIO[7:4];
        end
      end
      ST_EQIO: begin
        pins_d.cs_n = 1'b0;
        pins_d.sck  = sck_k[0];
        pins_d.sio  = {3'b111, SRAM_CMD_EQIO[3'd7 - sck_k[3:1]]};
      end
      ST_CMD: begin
        pins_d.cs_n = 1'b0;
        pins_d.sck  = sck_k[0];
        pins_d.sio  = sck_k[1] ? SRAM_CMD_READ[3:0] : SRAM_CMD_READ[7:4];
      end
      ST_ADDR: begin
        pins_d.cs_n = 1'b0;
        pins_d.sck  = sck_k[0];
        case (sck_k[3:1])
          3'd0:    pins_d.sio = addr_q[23:20];
          3'd1:    pins_d.sio = addr_q[19:16];
          3'd2:    pins_d.sio = addr_q[15:12];
          3'd3:    pins_d.sio = addr_q[11:8];
          3'd4:    pins_d.sio = addr_q[7:4];
          default: pins_d.sio = addr_q[3:0];
        endcase
      end
      ST_DUMMY, ST_DATA: begin
        pins_d.cs_n = 1'b0;
        pins_d.sck  = sck_k[0];
        pins_d.oe   = 1'b0;
      end
      default: pins_d = PINS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST_IO;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbank_q <= 1'b0;
      disp_q  <= 1'b0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pins_q  <= PINS_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbank_q <= wbank_d;
      disp_q  <= disp_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pins_q  <= pins_d;
    end
  end

  // Data nibbles are captured on the edge where SCK falls (odd counts)
  video_line_bank #(
    .WIDTH (SCREEN_WIDTH)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   ((state_q == ST_DATA) && cnt_q[0]),
    .wr_bank (wbank_q),
    .wr_idx  (NIB_AW'(cnt_q >> 1)),
    .wr_data (sram_sio_i),
    .rd_bank (disp_q),
    .rd_addr (rd_hpos),
    .rd_data (pixel_out)
  );

  assign initialized = init_q;
  assign fetch_busy  = busy_q;
  assign fetch_done  = done_q;
  assign sram_cs_n   = pins_q.cs_n;
  assign sram_sck    = pins_q.sck;
  assign sram_sio_oe = pins_q.oe;
  assign sram_sio_o  = pins_q.sio;

endmodule

// File: tb/tb_qspi_video_line_fetcher.sv
// Bench for qspi_video_line_fetcher: behavioural 23LC1024 model on the pins,
// per-bank pixel model, one task per feature.
module tb_qspi_video_line_fetcher;

  localparam int unsigned W = 512;
  localparam int unsigned N = W / 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_req = 1'b0;
  logic [9:0] fetch_line = '0;
  logic       swap = 1'b0;
  logic [9:0] rd_hpos = '0;
  logic [3:0] sram_sio_i = '0;
  logic       pixel_out, initialized, fetch_busy, fetch_done;
  logic       sram_cs_n, sram_sck, sram_sio_oe;
  logic [3:0] sram_sio_o;

  qspi_video_line_fetcher dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_line  (fetch_line),
    .swap        (swap),
    .rd_hpos     (rd_hpos),
    .pixel_out   (pixel_out),
    .initialized (initialized),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done),
    .sram_cs_n   (sram_cs_n),
    .sram_sck    (sram_sck),
    .sram_sio_oe (sram_sio_oe),
    .sram_sio_o  (sram_sio_o),
    .sram_sio_i  (sram_sio_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // SRAM model and pin monitor state
  logic [3:0] nib_src [N];
  logic [3:0] cap_nib [10];
  int  sck_j = 0, cs_run = 0, last_run = 0, cs_falls = 0;
  int  done_cnt = 0, done_bad = 0, busy_clks = 0;
  logic prev_cs = 1'b1;

  // Reference pixel model
  bit exp_bank [2][W];
  bit exp_valid [2];
  int disp_m = 0;

  // SRAM model: drive nibble k for SCK cycle 10+k while SCK is low; capture
  // command/address nibbles while SCK is high.
  always @(negedge clk) begin
    if (sram_cs_n) begin
      if (!prev_cs) last_run = cs_run;
      cs_run = 0;
      sck_j  = 0;
    end else begin
      if (prev_cs) cs_falls++;
      cs_run++;
      if (!sram_sck) begin
        sram_sio_i = (sck_j >= 10 && sck_j < 10 + N) ? nib_src[sck_j - 10] : 4'h0;
      end else begin
        if (sck_j < 10) cap_nib[sck_j] = sram_sio_o;
        sck_j++;
      end
    end
    if (fetch_done) begin
      done_cnt++;
      if (!(sram_cs_n && !prev_cs)) done_bad++;
    end
    if (fetch_busy) busy_clks++;
    prev_cs = sram_cs_n;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
    disp_m ^= 1;
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) nib_src[k] = 4'($urandom_range(15, 0));
  endtask

  task automatic model_store(input int wb);
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 4; i++) exp_bank[wb][4 * k + i] = nib_src[k][3 - i];
    exp_valid[wb] = 1'b1;
  endtask

  task automatic pulse_req(input logic [9:0] line);
    fetch_line = line;
    fetch_req  = 1'b1;
    tick();
    fetch_req  = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 400) begin tick(); t++; end
    repeat (3) tick();
  endtask

  // Count of command/address nibbles that differ from READ + expected address
  function automatic int addr_errs(input int line);
    logic [23:0] a;
    logic [3:0]  e;
    int bad = 0;
    a = 24'(line * (W / 8));
    for (int j = 0; j < 8; j++) begin
      if (j == 0)      e = 4'h0;
      else if (j == 1) e = 4'h3;
      else             e = 4'(a >> (20 - 4 * (j - 2)));
      if (cap_nib[j] !== e) bad++;
    end
    return bad;
  endfunction

  task automatic check_readback(input string tag);
    int bad = 0, first = -1, h;
    bit e;
    for (int i = 0; i < W + 16; i++) begin
      h = (i < W + 8) ? i : int'($urandom_range(1023, W));
      rd_hpos = 10'(h);
      tick();
      e = (h < W) ? exp_bank[disp_m][h] : 1'b0;
      if (pixel_out !== e) begin bad++; if (first < 0) first = h; end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL readback_%s: %0d wrong pixels (first hpos %0d), required 0", tag, bad, first);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_tests += 8;
    if (sram_cs_n !== 1'b1)   begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", sram_cs_n); end
    if (sram_sck !== 1'b0)    begin n_fail++; $display("FAIL rst_sck: got %b want 0", sram_sck); end
    if (sram_sio_oe !== 1'b1) begin n_fail++; $display("FAIL rst_oe: got %b want 1", sram_sio_oe); end
    if (sram_sio_o !== 4'hF)  begin n_fail++; $display("FAIL rst_sio: got %h want f", sram_sio_o); end
    if (pixel_out !== 1'b0)   begin n_fail++; $display("FAIL rst_pixel: got %b want 0", pixel_out); end
    if (initialized !== 1'b0) begin n_fail++; $display("FAIL rst_init: got %b want 0", initialized); end
    if (fetch_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b want 0", fetch_busy); end
    if (fetch_done !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %b want 0", fetch_done); end
  endtask

  // Releases reset and checks the RSTIO/EQIO sequence; optionally issues a
  // fetch before initialisation, which must be dropped.
  task automatic check_init(input bit poke);
    int seg = -1, rst_cnt = 0, eq_cnt = 0, bad = 0, init_at = -1, f0, d0;
    logic [7:0] eq_byte = '0;
    logic p = 1'b1;
    f0 = cs_falls;
    d0 = done_cnt;
    reset = 1'b0;
    disp_m = 0;
    exp_valid[0] = 1'b0;
    exp_valid[1] = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (poke && c == 5) begin fetch_line = 10'd3; fetch_req = 1'b1; end
      if (c == 6) fetch_req = 1'b0;
      tick();
      if (!sram_cs_n && p) seg++;
      if (!sram_cs_n && sram_sck) begin
        if (seg == 0) begin
          rst_cnt++;
          if (sram_sio_o !== 4'hF || sram_sio_oe !== 1'b1) bad++;
        end else if (seg == 1) begin
          eq_cnt++;
          eq_byte = {eq_byte[6:0], sram_sio_o[0]};
          if (sram_sio_o[3] !== 1'b1 || sram_sio_oe !== 1'b1) bad++;
        end
      end
      if (initialized === 1'b1 && init_at < 0) init_at = c;
      p = sram_cs_n;
    end
    repeat (20) tick();
    n_tests += 7;
    if (rst_cnt != 8)    begin n_fail++; $display("FAIL init_rstio_sck: got %0d want 8", rst_cnt); end
    if (eq_cnt != 8)     begin n_fail++; $display("FAIL init_eqio_sck: got %0d want 8", eq_cnt); end
    if (eq_byte !== 8'h38) begin n_fail++; $display("FAIL init_eqio_byte: got %h want 38", eq_byte); end
    if (bad != 0)        begin n_fail++; $display("FAIL init_sio_lines: got %0d bad SCK want 0", bad); end
    if (init_at < 1 || init_at > 40) begin n_fail++; $display("FAIL init_time: got clk %0d want 1..40", init_at); end
    if (cs_falls - f0 != 2) begin n_fail++; $display("FAIL init_cs_bursts: got %0d want 2", cs_falls - f0); end
    if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL init_no_done: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_fetch_line3();
    int f0, d0, b0, wb;
    bit exp_pix [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < N; k++) nib_src[k] = 4'(k % 16);
    f0 = cs_falls; d0 = done_cnt; b0 = busy_clks; wb = 1 - disp_m;
    pulse_req(10'd3);
    wait_done(d0);
    n_tests += 6;
    if (done_cnt - d0 != 1)  begin n_fail++; $display("FAIL l3_done: got %0d want 1", done_cnt - d0); end
    if (cs_falls - f0 != 1)  begin n_fail++; $display("FAIL l3_cs_bursts: got %0d want 1", cs_falls - f0); end
    if (last_run != 276)     begin n_fail++; $display("FAIL l3_cs_low: got %0d want 276", last_run); end
    if (busy_clks - b0 != 277) begin n_fail++; $display("FAIL l3_busy: got %0d want 277", busy_clks - b0); end
    if (done_bad != 0)       begin n_fail++; $display("FAIL l3_done_timing: got %0d want 0", done_bad); end
    if (addr_errs(3) != 0)   begin n_fail++; $display("FAIL l3_cmd_addr: got %0d bad nibbles (addr %h%h%h%h%h%h) want 0 (00000c0)", addr_errs(3), cap_nib[2], cap_nib[3], cap_nib[4], cap_nib[5], cap_nib[6], cap_nib[7]); end
    model_store(wb);
    do_swap();
    for (int h = 0; h < 8; h++) begin
      rd_hpos = 10'(h);
      tick();
      n_tests++;
      if (pixel_out !== exp_pix[h]) begin n_fail++; $display("FAIL l3_pixel%0d: got %b want %b", h, pixel_out, exp_pix[h]); end
    end
  endtask

  task automatic test_bad_line();
    int f0, d0;
    logic [9:0] lines [3] = '{10'd256, 10'd300, 10'd1023};
    for (int i = 0; i < 3; i++) begin
      f0 = cs_falls; d0 = done_cnt;
      pulse_req(lines[i]);
      repeat (30) tick();
      n_tests += 2;
      if (cs_falls - f0 != 0) begin n_fail++; $display("FAIL bad_line_cs_%0d: got %0d bursts want 0", lines[i], cs_falls - f0); end
      if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL bad_line_done_%0d: got %0d want 0", lines[i], done_cnt - d0); end
    end
  endtask

  task automatic test_random_fetch();
    int d0, wb, line;
    for (int it = 0; it < 3; it++) begin
      fill_random();
      line = int'($urandom_range(255, 0));
      d0 = done_cnt; wb = 1 - disp_m;
      pulse_req(10'(line));
      wait_done(d0);
      n_tests += 3;
      if (done_cnt - d0 != 1)  begin n_fail++; $display("FAIL rnd_done_%0d: got %0d want 1", it, done_cnt - d0); end
      if (last_run != 276)     begin n_fail++; $display("FAIL rnd_cs_low_%0d: got %0d want 276", it, last_run); end
      if (addr_errs(line) != 0) begin n_fail++; $display("FAIL rnd_addr_%0d: got %0d bad nibbles for line %0d want 0", it, addr_errs(line), line); end
      model_store(wb);
      do_swap();
      check_readback($sformatf("rnd%0d", it));
    end
  endtask

  task automatic test_busy_swap();
    int f0, d0, wb, line, t = 0;
    fill_random();
    line = int'($urandom_range(255, 0));
    f0 = cs_falls; d0 = done_cnt; wb = 1 - disp_m;
    pulse_req(10'(line));
    repeat (30) tick();
    pulse_req(10'((line + 7) % 256));
    repeat (20) tick();
    do_swap();
    while (fetch_done !== 1'b1 && t < 400) begin tick(); t++; end
    pulse_req(10'd5);
    repeat (30) tick();
    n_tests += 4;
    if (cs_falls - f0 != 1)  begin n_fail++; $display("FAIL busy_cs_bursts: got %0d want 1", cs_falls - f0); end
    if (done_cnt - d0 != 1)  begin n_fail++; $display("FAIL busy_done: got %0d want 1", done_cnt - d0); end
    if (last_run != 276)     begin n_fail++; $display("FAIL busy_cs_low: got %0d want 276", last_run); end
    if (addr_errs(line) != 0) begin n_fail++; $display("FAIL busy_addr: got %0d bad nibbles for line %0d want 0", addr_errs(line), line); end
    model_store(wb);
    check_readback("swap_target");
    do_swap();
    check_readback("swap_other");
  endtask

  task automatic test_reset_mid();
    int d0;
    fill_random();
    d0 = done_cnt;
    pulse_req(10'($urandom_range(255, 0)));
    repeat (49) tick();
    reset = 1'b1;
    tick();
    n_tests += 2;
    if (sram_cs_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cs_n: got %b want 1", sram_cs_n); end
    if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", fetch_busy); end
    tick();
    check_init(1'b0);
    n_tests++;
    if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL mid_rst_done: got %0d want 0", done_cnt - d0); end
    // Block must work again after the re-init
    fill_random();
    d0 = done_cnt;
    pulse_req(10'd17);
    wait_done(d0);
    n_tests++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL post_rst_done: got %0d want 1", done_cnt - d0); end
    model_store(1 - disp_m);
    do_swap();
    check_readback("post_rst");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    check_init(1'b1);
    test_fetch_line3();
    test_bad_line();
    test_random_fetch();
    test_busy_swap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_video_line_fetcher.md
QSPI_VIDEO_LINE_FETCHER -- requirements
Module: qspi_video_line_fetcher

Interface
REQ-001 The block SHALL have parameter SCREEN_WIDTH, default 512, meaning pixels per line (multiple of 8).
REQ-002 The block SHALL have parameter SCREEN_HEIGHT, default 256, meaning number of fetchable lines.
REQ-003 The block SHALL have parameter BASE_ADDR, default 24'h000000, meaning SRAM byte address of line 0.
REQ-004 The block SHALL have port clk, input, 1 bit, system clock.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high; clock clk.
REQ-006 The block SHALL have port fetch_req, input, 1 bit, single-cycle request to fetch one line.
REQ-007 The block SHALL have port fetch_line, input, 10 bits, line number sampled with fetch_req.
REQ-008 The block SHALL have port swap, input, 1 bit, pulse toggling the display bank.
REQ-009 The block SHALL have port rd_hpos, input, 10 bits, pixel index to display.
REQ-010 The block SHALL have port pixel_out, output, 1 bit, registered pixel value.
REQ-011 The block SHALL have ports initialized, fetch_busy and fetch_done, outputs, 1 bit each: init complete, transaction active, one-cycle completion pulse.
REQ-012 The block SHALL have outputs sram_cs_n, sram_sck and sram_sio_oe, 1 bit each, plus sram_sio_o (output, 4 bits) and sram_sio_i (input, 4 bits); bit 3 is HOLD_N/SIO3.

Function
REQ-013 The SCK rate SHALL be clk/2, idle low. The master SHALL change SIO outputs while SCK is low, and SHALL sample sram_sio_i on the clk edge where SCK falls.
REQ-014 The FSM states SHALL be RST_IO, GAP1, EQIO, GAP2, IDLE, CMD, ADDR, DUMMY, DATA, END.
REQ-015 The init sequence SHALL be as follows.
- RST_IO: 8 SCK cycles, sio_o=4'b1111.
- GAP1: CS_n high for 2 clk.
- EQIO: 8 SCK cycles, SPI mode, sending 0x38 MSB-first on sio_o[0], with sio_o[3]=1.
- GAP2: CS_n high for 2 clk.
- Then initialized=1 and the FSM enters IDLE.
REQ-016 In IDLE, fetch_req SHALL start a transaction only when initialized=1 and fetch_line<SCREEN_HEIGHT; otherwise it SHALL be dropped with no fetch_done.
REQ-017 fetch_req SHALL be ignored while fetch_busy=1.
REQ-018 Each transaction SHALL be sent in SQI mode, nibble MSB-first, in this order:
- CMD: 2 nibbles of 0x03.
- ADDR: 6 nibbles of BASE_ADDR + fetch_line*(SCREEN_WIDTH/8), truncated to 24 bits.
- DUMMY: 2 SCK cycles.
- DATA: N=SCREEN_WIDTH/4 nibbles.
REQ-019 sram_cs_n SHALL fall the cycle after an accepted fetch_req and stay low exactly 2*(10+N) clk. fetch_done SHALL pulse the cycle after CS_n rises (END); the FSM then returns to IDLE.
REQ-020 fetch_busy SHALL be high from the cycle after acceptance through the fetch_done cycle inclusive.
REQ-021 sram_sio_oe SHALL be 0 during DUMMY and DATA, and 1 otherwise. sio_o[3] SHALL be 1 whenever oe=1 outside SQI phases.
REQ-022 Data nibble k SHALL write pixels 4k..4k+3 with sio[3] equal to pixel 4k, into the write bank.
REQ-023 The write bank SHALL be the complement of the display bank, latched at transaction acceptance; swap mid-transaction SHALL NOT retarget the write.
REQ-024 swap SHALL toggle the display bank the following cycle, in any state.
REQ-025 pixel_out SHALL equal bank[display][rd_hpos] one clk after rd_hpos is presented, and 0 when rd_hpos>=SCREEN_WIDTH.
REQ-026 fetch_req coincident with fetch_done SHALL be ignored.

Reset
REQ-027 On reset the FSM SHALL enter RST_IO at counter 0, with initialized=0, fetch_busy=0, fetch_done=0, sram_cs_n=1, sram_sck=0, sram_sio_oe=1, sram_sio_o=4'b1111, pixel_out=0, display bank=0.
REQ-028 Reset mid-transaction SHALL abort it (CS_n high next cycle) with no fetch_done and SHALL rerun the init sequence; line-bank contents are undefined.

Structure
REQ-029 A shared package SHALL hold the 23LC1024 instruction codes (READ 0x03, EQIO 0x38, RSTIO 0xFF), the FSM state enum and the phase lengths (CMD 2, ADDR 6, DUMMY 2).
REQ-030 The ping-pong storage SHALL be a sub-module video_line_bank: 2 x SCREEN_WIDTH bits, with a 4-bit write port and a 1-bit registered read port.

Verification
REQ-031 After reset release, the bench SHALL observe 8 SCK with sio=1111, then 8 SCK carrying 0x38 on sio0, and initialized=1 within 40 clk.
REQ-032 fetch_req with fetch_line=3 (defaults) SHALL produce address nibbles 0,0,0,0,C,0, CS_n low for 276 clk, and fetch_done.
REQ-033 With a model returning nibble=k mod 16 and swap after done, rd_hpos=0..7 SHALL give pixel_out 0,0,0,0,0,0,0,1.
REQ-034 fetch_line=256 or fetch_req before initialized SHALL give no CS_n activity and no fetch_done.
REQ-035 A second fetch_req during busy SHALL be ignored; swap mid-fetch SHALL still fill the originally latched bank.
REQ-036 Reset asserted 50 clk into a fetch SHALL give CS_n=1 next cycle, no fetch_done, and the init sequence repeated.
